// File: rtl/datapath_o.sv
// -----------------------------------------------------------------------------
// datapath_o
//
// Execution datapath for the control_o sequencer. Each cycle the 16-bit
// control word is decoded into two operand selects, an ALU operation, a
// destination register and a write strobe. The registered flags mayor/zero/neg
// feed the sequencer's branch logic. A host port loads and reads the register
// file around a run.
//
// Ports:
//   clk        in            rising-edge clock
//   rst        in            synchronous active-high reset (clears R0..R15 and flags)
//   i_signal   in  [15:0]    control word {cnt_alu[2:0], slc_mux_a[3:0],
//                            slc_mux_b[3:0], slc_reg[3:0], w}
//   load_en    in            host write strobe
//   load_addr  in  [3:0]     host write index
//   load_data  in  [WIDTH-1:0] host write data
//   rd_addr    in  [3:0]     host read index
//   rd_data    out [WIDTH-1:0] combinational R[rd_addr]
//   alu_out    out [WIDTH-1:0] combinational ALU result for i_signal
//   mayor      out           registered A > B (unsigned)
//   zero       out           registered result == 0
//   neg        out           registered result MSB
// -----------------------------------------------------------------------------
module datapath_o #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_signal,
  input  logic             load_en,
  input  logic [3:0]       load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_out,
  output logic             mayor,
  output logic             zero,
  output logic             neg
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_PSA = 3'b100;
  localparam logic [2:0] OP_PSB = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // ALU core; carry and borrow fall off the top because the result is WIDTH bits.
  function automatic logic [WIDTH-1:0] alu_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_NOP: r = '0;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_PSA: r = a;
      OP_PSB: r = b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---- stage p0: decode, operand read, ALU (all combinational) ----
  logic [2:0]       op_p0;
  logic [3:0]       sel_a_p0;
  logic [3:0]       sel_b_p0;
  logic [3:0]       dst_p0;
  logic             w_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] res_p0;
  logic             alu_wr_p0;

  logic [WIDTH-1:0] rf [16];

  assign op_p0    = i_signal[15:13];
  assign sel_a_p0 = i_signal[12:9];
  assign sel_b_p0 = i_signal[8:5];
  assign dst_p0   = i_signal[4:1];
  assign w_p0     = i_signal[0];

  // Reads see the pre-edge contents, so self-reference uses the old value.
  assign a_p0    = rf[sel_a_p0];
  assign b_p0    = rf[sel_b_p0];
  assign res_p0  = alu_f(op_p0, a_p0, b_p0);
  assign alu_out = res_p0;
  assign rd_data = rf[rd_addr];

  // A host load to the same index takes priority over ALU write-back.
  assign alu_wr_p0 = w_p0 && !(load_en && (load_addr == dst_p0));

  // ---- stage p1: register file and flag registers ----
  logic mayor_p1;
  logic zero_p1;
  logic neg_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (alu_wr_p0) begin
        rf[dst_p0] <= res_p0;
      end
      if (load_en) begin
        rf[load_addr] <= load_data;
      end
    end
  end

  // NOP keeps the flags so the sequencer's idle word does not disturb a pending branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mayor_p1 <= 1'b0;
      zero_p1  <= 1'b0;
      neg_p1   <= 1'b0;
    end else if (op_p0 != OP_NOP) begin
      mayor_p1 <= (a_p0 > b_p0);
      zero_p1  <= (res_p0 == '0);
      neg_p1   <= res_p0[WIDTH-1];
    end
  end

  assign mayor = mayor_p1;
  assign zero  = zero_p1;
  assign neg   = neg_p1;

endmodule

// File: tb/tb_datapath_o.sv
module tb_datapath_o;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [15:0]      i_signal;
  logic             load_en;
  logic [3:0]       load_addr;
  logic [WIDTH-1:0] load_data;
  logic [3:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] alu_out;
  logic             mayor;
  logic             zero;
  logic             neg;

  int n_vec;
  int n_err;

  datapath_o #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_signal  (i_signal),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .alu_out   (alu_out),
    .mayor     (mayor),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values are those visible after the inputs settle, before the next
  // rising edge; flags ({mayor,zero,neg}) therefore reflect the previous edge.
  typedef struct packed {
    logic       rst;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] rg;
    logic       w;
    logic       le;
    logic [3:0] la;
    logic [7:0] ld;
    logic [3:0] ra;
    logic [7:0] erd;
    logic [7:0] ealu;
    logic [2:0] ef;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic       rst_i,
    input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
    input logic [3:0] rg, input logic w,
    input logic       le, input logic [3:0] la, input logic [7:0] ld,
    input logic [3:0] ra,
    input logic [7:0] erd, input logic [7:0] ealu, input logic [2:0] ef
  );
    vec_t v;
    v.rst = rst_i; v.op = op; v.a = a; v.b = b; v.rg = rg; v.w = w;
    v.le = le; v.la = la; v.ld = ld; v.ra = ra;
    v.erd = erd; v.ealu = ealu; v.ef = ef;
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t v);
    logic bad;
    bad = 1'b0;
    n_vec++;
    if (rd_data !== v.erd) begin
      $display("FAIL %s rd_data: got %h expected %h", name, rd_data, v.erd);
      bad = 1'b1;
    end
    if (alu_out !== v.ealu) begin
      $display("FAIL %s alu_out: got %h expected %h", name, alu_out, v.ealu);
      bad = 1'b1;
    end
    if ({mayor, zero, neg} !== v.ef) begin
      $display("FAIL %s flags{mayor,zero,neg}: got %b expected %b", name,
               {mayor, zero, neg}, v.ef);
      bad = 1'b1;
    end
    if (bad) n_err++;
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    i_signal  = {v.op, v.a, v.b, v.rg, v.w};
    load_en   = v.le;
    load_addr = v.la;
    load_data = v.ld;
    rd_addr   = v.ra;
  endtask

  task automatic chk1(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; i_signal = '0; load_en = 1'b0; load_addr = '0;
    load_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    //        rst op    a  b  rg w  le la  ld     ra  erd    ealu   ef
    // reset: load R3=55, then reset with writes active
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 3, 8'h55, 3, 8'h00, 8'h00, 3'b000));
    tv.push_back(mk(1, 3'd1, 3, 3, 7, 1, 1, 3, 8'hAA, 3, 8'h55, 8'hAA, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 3, 8'h00, 8'h00, 3'b000));
    // subtract flags: R1=5, R0=9, 5-9
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 1, 8'h05, 7, 8'h00, 8'h00, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 0, 8'h09, 1, 8'h05, 8'h00, 3'b000));
    tv.push_back(mk(0, 3'd2, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h09, 8'hFC, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h05, 8'h00, 3'b001));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h09, 8'h00, 3'b001));
    // swap through R6: R0=3, R1=7
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 0, 8'h03, 0, 8'h09, 8'h00, 3'b001));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 1, 8'h07, 0, 8'h03, 8'h00, 3'b001));
    tv.push_back(mk(0, 3'd4, 1, 0, 6, 1, 0, 0, 8'h00, 1, 8'h07, 8'h07, 3'b001));
    tv.push_back(mk(0, 3'd4, 0, 0, 1, 1, 0, 0, 8'h00, 6, 8'h07, 8'h03, 3'b100));
    tv.push_back(mk(0, 3'd4, 6, 0, 0, 1, 0, 0, 8'h00, 1, 8'h03, 8'h07, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 3'b100));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 6, 8'h07, 8'h00, 3'b100));
    // collision: R2=10, R3=01, then load R4 vs ALU write R4, then R5
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 2, 8'h10, 1, 8'h03, 8'h00, 3'b100));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 3, 8'h01, 2, 8'h10, 8'h00, 3'b100));
    tv.push_back(mk(0, 3'd1, 2, 3, 4, 1, 1, 4, 8'hAA, 4, 8'h00, 8'h11, 3'b100));
    tv.push_back(mk(0, 3'd1, 2, 3, 5, 1, 1, 4, 8'hAA, 4, 8'hAA, 8'h11, 3'b100));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 4, 8'hAA, 8'h00, 3'b100));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 5, 8'h11, 8'h00, 3'b100));
    // NOP hold: A-A sets zero, then five idle words
    tv.push_back(mk(0, 3'd2, 5, 5, 0, 0, 0, 0, 8'h00, 5, 8'h11, 8'h00, 3'b100));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 4, 8'hAA, 8'h00, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 5, 8'h11, 8'h00, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 6, 8'h07, 8'h00, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h03, 8'h00, 3'b010));
    // wrap and self-reference: R2=FF, R2 <= R2+R2
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 2, 8'hFF, 2, 8'h10, 8'h00, 3'b010));
    tv.push_back(mk(0, 3'd1, 2, 2, 2, 1, 0, 0, 8'h00, 2, 8'hFF, 8'hFE, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 2, 8'hFE, 8'h00, 3'b001));
    // remaining ops: AND, OR, pass B, XOR (self-xor written to R6)
    tv.push_back(mk(0, 3'd3, 4, 6, 0, 0, 0, 0, 8'h00, 3, 8'h01, 8'h02, 3'b001));
    tv.push_back(mk(0, 3'd6, 4, 5, 0, 0, 0, 0, 8'h00, 4, 8'hAA, 8'hBB, 3'b100));
    tv.push_back(mk(0, 3'd5, 0, 4, 0, 0, 0, 0, 8'h00, 0, 8'h07, 8'hAA, 3'b101));
    tv.push_back(mk(0, 3'd7, 4, 4, 6, 1, 0, 0, 8'h00, 0, 8'h07, 8'h00, 3'b001));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 6, 8'h00, 8'h00, 3'b010));
    // mid-sequence reset with an active XOR write
    tv.push_back(mk(1, 3'd7, 0, 1, 0, 1, 0, 0, 8'h00, 0, 8'h07, 8'h04, 3'b010));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 5, 8'h00, 8'h00, 3'b000));
    tv.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 8'h00, 2, 8'h00, 8'h00, 3'b000));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check_vec($sformatf("vec%0d", i), tv[i]);
    end

    // Compare word issued on two consecutive cycles before branching on neg.
    @(negedge clk);
    rst = 1'b0; i_signal = '0; load_en = 1'b1; load_addr = 4'd8; load_data = 8'h02;
    @(negedge clk);
    load_addr = 4'd9; load_data = 8'h03;
    @(negedge clk);
    load_en = 1'b0; i_signal = {3'd2, 4'd8, 4'd9, 4'd0, 1'b0};
    #1;
    chk1("cmp1_alu", alu_out, 8'hFF);
    chk1("cmp1_neg_before", {7'd0, neg}, 8'h00);
    @(negedge clk);
    #1;
    chk1("cmp2_neg", {7'd0, neg}, 8'h01);
    chk1("cmp2_mayor_zero", {6'd0, mayor, zero}, 8'h00);
    @(negedge clk);
    i_signal = '0; rd_addr = 4'd0;
    #1;
    chk1("cmp_hold_neg", {7'd0, neg}, 8'h01);
    chk1("cmp_no_write_r0", rd_data, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
